// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer scheduler: states, grant bit positions,
// default timing constants and small helper functions.
package buzzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALARM,
        ST_CHIME_ON,
        ST_CHIME_GAP,
        ST_KEY
    } state_t;

    localparam int GNT_ALARM = 2;
    localparam int GNT_CHIME = 1;
    localparam int GNT_KEY   = 0;

    localparam int DEF_ALARM_SEC    = 30;
    localparam int DEF_MELODY_SEC   = 2;
    localparam int DEF_TONE_HI_HALF = 1;
    localparam int DEF_TONE_LO_HALF = 2;
    localparam int DEF_CHIME_ON     = 200;
    localparam int DEF_CHIME_GAP    = 200;
    localparam int DEF_KEY_LEN      = 50;

    localparam logic [3:0] MAX_CHIME = 4'd12;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A chime count of 0 or anything above 12 plays the full twelve beeps.
    function automatic logic [3:0] norm_count(input logic [3:0] c);
        return ((c == 4'd0) || (c > MAX_CHIME)) ? MAX_CHIME : c;
    endfunction

endpackage

// File: rtl/buzzer_sched_if.sv
// Request/response bundle between the timekeeping logic and the buzzer scheduler.
interface buzzer_sched_if;
    logic       tick_1hz;
    logic       alarm_req;
    logic       alarm_stop;
    logic       chime_req;
    logic [3:0] chime_count;
    logic       key_req;
    logic       buzzer;
    logic [2:0] grant;
    logic       busy;
    logic       alarm_flag;

    modport master (
        output tick_1hz, alarm_req, alarm_stop, chime_req, chime_count, key_req,
        input  buzzer, grant, busy, alarm_flag
    );

    modport slave (
        input  tick_1hz, alarm_req, alarm_stop, chime_req, chime_count, key_req,
        output buzzer, grant, busy, alarm_flag
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator with two selectable half-periods. The enable, select and
// restart inputs describe the upcoming cycle, so a restart or disable takes
// effect on the same edge the scheduler changes state.
module tone_gen
    import buzzer_pkg::*;
#(
    parameter int HI_HALF = DEF_TONE_HI_HALF,
    parameter int LO_HALF = DEF_TONE_LO_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    input  logic sel_lo,
    output logic wave
);

    localparam int MAXH = (HI_HALF > LO_HALF) ? HI_HALF : LO_HALF;
    localparam int HW   = cnt_width(MAXH);
    localparam logic [HW-1:0] HI_LAST = HW'(HI_HALF - 1);
    localparam logic [HW-1:0] LO_LAST = HW'(LO_HALF - 1);

    logic [HW-1:0] half_cnt;
    logic [HW-1:0] last;

    assign last = sel_lo ? LO_LAST : HI_LAST;

    // Count out each half-period and flip the output; silence and phase reset when disabled or restarted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_cnt <= '0;
            wave     <= 1'b0;
        end else if (!en || restart) begin
            half_cnt <= '0;
            wave     <= 1'b0;
        end else if (half_cnt >= last) begin
            half_cnt <= '0;
            wave     <= ~wave;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/buzzer_sched.sv
// Single-buzzer scheduler: arbitrates alarm, hourly chime and key click onto one
// piezo output with fixed priority (alarm > chime > key) and preemption.
module buzzer_sched
    import buzzer_pkg::*;
#(
    parameter int ALARM_SEC    = DEF_ALARM_SEC,
    parameter int MELODY_SEC   = DEF_MELODY_SEC,
    parameter int TONE_HI_HALF = DEF_TONE_HI_HALF,
    parameter int TONE_LO_HALF = DEF_TONE_LO_HALF,
    parameter int CHIME_ON     = DEF_CHIME_ON,
    parameter int CHIME_GAP    = DEF_CHIME_GAP,
    parameter int KEY_LEN      = DEF_KEY_LEN
) (
    input logic           clk,
    input logic           rst,
    buzzer_sched_if.slave bus
);

    localparam int MAXC_A = (CHIME_ON > CHIME_GAP) ? CHIME_ON : CHIME_GAP;
    localparam int MAXC   = (MAXC_A > KEY_LEN) ? MAXC_A : KEY_LEN;
    localparam int SW     = cnt_width(ALARM_SEC);
    localparam int PW     = cnt_width(MELODY_SEC);
    localparam int CW     = cnt_width(MAXC);

    localparam logic [SW-1:0] SEC_LAST = SW'(ALARM_SEC - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(MELODY_SEC - 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(CHIME_ON - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(CHIME_GAP - 1);
    localparam logic [CW-1:0] KEY_LOAD = CW'(KEY_LEN - 1);

    state_t        state_q, state_n;
    logic [SW-1:0] sec_q, sec_n;
    logic [PW-1:0] ph_q, ph_n;
    logic          lo_q, lo_n;
    logic [CW-1:0] cyc_q, cyc_n;
    logic [3:0]    left_q, left_n;
    logic [3:0]    orig_q, orig_n;
    logic          pend_q, pend_n;
    logic [3:0]    pcnt_q, pcnt_n;
    logic          armed_q, armed_n;
    logic [2:0]    grant_q, grant_n;
    logic          busy_q, aflag_q;

    logic          alarm_start;
    logic [3:0]    req_cnt;
    logic          launch;
    logic [3:0]    launch_cnt;
    logic          tone_en, tone_restart, tone_lo;

    assign alarm_start = bus.alarm_req && armed_q && (state_q != ST_ALARM);
    assign req_cnt     = norm_count(bus.chime_count);

    // State and counter registers; armed comes out of reset set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            ph_q    <= '0;
            lo_q    <= 1'b0;
            cyc_q   <= '0;
            left_q  <= '0;
            orig_q  <= '0;
            pend_q  <= 1'b0;
            pcnt_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_n;
            sec_q   <= sec_n;
            ph_q    <= ph_n;
            lo_q    <= lo_n;
            cyc_q   <= cyc_n;
            left_q  <= left_n;
            orig_q  <= orig_n;
            pend_q  <= pend_n;
            pcnt_q  <= pcnt_n;
            armed_q <= armed_n;
        end
    end

    // Next-state logic: alarm start overrides everything, otherwise each state runs its own sequence.
    always_comb begin
        state_n    = state_q;
        sec_n      = sec_q;
        ph_n       = ph_q;
        lo_n       = lo_q;
        cyc_n      = cyc_q;
        left_n     = left_q;
        orig_n     = orig_q;
        pend_n     = pend_q;
        pcnt_n     = pcnt_q;
        armed_n    = armed_q;
        launch     = 1'b0;
        launch_cnt = req_cnt;

        if (!armed_q && !bus.alarm_req) begin
            armed_n = 1'b1;
        end

        if (alarm_start) begin
            state_n = ST_ALARM;
            sec_n   = '0;
            ph_n    = '0;
            lo_n    = 1'b0;
            if ((state_q == ST_CHIME_ON) || (state_q == ST_CHIME_GAP)) begin
                pend_n = 1'b1;
                pcnt_n = orig_q;
            end else if (bus.chime_req) begin
                pend_n = 1'b1;
                pcnt_n = req_cnt;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.chime_req) begin
                        launch     = 1'b1;
                        launch_cnt = req_cnt;
                        pend_n     = 1'b0;
                    end else if (pend_q) begin
                        launch     = 1'b1;
                        launch_cnt = pcnt_q;
                        pend_n     = 1'b0;
                    end else if (bus.key_req) begin
                        state_n = ST_KEY;
                        cyc_n   = KEY_LOAD;
                    end
                end
                ST_ALARM: begin
                    if (bus.chime_req) begin
                        pend_n = 1'b1;
                        pcnt_n = req_cnt;
                    end
                    if (bus.alarm_stop || (bus.tick_1hz && (sec_q == SEC_LAST))) begin
                        state_n = ST_IDLE;
                        armed_n = 1'b0;
                        lo_n    = 1'b0;
                    end else if (bus.tick_1hz) begin
                        sec_n = sec_q + 1'b1;
                        if (ph_q == PH_LAST) begin
                            ph_n = '0;
                            lo_n = ~lo_q;
                        end else begin
                            ph_n = ph_q + 1'b1;
                        end
                    end
                end
                ST_CHIME_ON: begin
                    if (cyc_q == '0) begin
                        left_n = left_q - 4'd1;
                        if (left_q == 4'd1) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_CHIME_GAP;
                            cyc_n   = GAP_LOAD;
                        end
                    end else begin
                        cyc_n = cyc_q - 1'b1;
                    end
                end
                ST_CHIME_GAP: begin
                    if (cyc_q == '0) begin
                        state_n = ST_CHIME_ON;
                        cyc_n   = ON_LOAD;
                    end else begin
                        cyc_n = cyc_q - 1'b1;
                    end
                end
                ST_KEY: begin
                    if (bus.chime_req) begin
                        launch     = 1'b1;
                        launch_cnt = req_cnt;
                    end else if (cyc_q == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        cyc_n = cyc_q - 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase

            if (launch) begin
                state_n = ST_CHIME_ON;
                cyc_n   = ON_LOAD;
                left_n  = launch_cnt;
                orig_n  = launch_cnt;
            end
        end
    end

    // Decode the upcoming state into the one-hot grant.
    always_comb begin
        grant_n = '0;
        case (state_n)
            ST_ALARM:                  grant_n[GNT_ALARM] = 1'b1;
            ST_CHIME_ON, ST_CHIME_GAP: grant_n[GNT_CHIME] = 1'b1;
            ST_KEY:                    grant_n[GNT_KEY]   = 1'b1;
            default:                   grant_n = '0;
        endcase
    end

    // Register the status outputs so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            aflag_q <= 1'b0;
        end else begin
            grant_q <= grant_n;
            busy_q  <= (state_n != ST_IDLE);
            aflag_q <= (state_n == ST_ALARM);
        end
    end

    assign tone_en      = (state_n == ST_ALARM) || (state_n == ST_CHIME_ON) || (state_n == ST_KEY);
    assign tone_lo      = (state_n == ST_ALARM) && lo_n;
    assign tone_restart = (state_n != state_q) || (lo_n != lo_q);

    tone_gen #(
        .HI_HALF (TONE_HI_HALF),
        .LO_HALF (TONE_LO_HALF)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (tone_restart),
        .sel_lo  (tone_lo),
        .wave    (bus.buzzer)
    );

    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.alarm_flag = aflag_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed testbench for buzzer_sched with default timing parameters.
module tb_buzzer_sched;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    buzzer_sched_if bus();

    buzzer_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #9;
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL reset_buzzer got=%b want=0", bus.buzzer); end
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL reset_grant got=%b want=000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.alarm_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_alarm_flag got=%b want=0", bus.alarm_flag); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_chime_three();
        logic exp_bz;
        bus.chime_count = 4'd3; bus.chime_req = 1'b1;
        @(negedge clk); bus.chime_req = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            exp_bz = (((i / 200) % 2) == 0) && (((i % 200) % 2) == 1);
            checks++; if (bus.grant !== 3'b010) begin failures++; $display("[TB] FAIL chime3_grant cyc=%0d got=%b want=010", i, bus.grant); end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL chime3_busy cyc=%0d got=%b want=1", i, bus.busy); end
            checks++; if (bus.buzzer !== exp_bz) begin failures++; $display("[TB] FAIL chime3_buzzer cyc=%0d got=%b want=%b", i, bus.buzzer, exp_bz); end
            @(negedge clk);
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL chime3_end_busy got=%b want=0", bus.busy); end
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL chime3_end_grant got=%b want=000", bus.grant); end
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL chime3_end_buzzer got=%b want=0", bus.buzzer); end
        @(negedge clk);
    endtask

    task automatic test_alarm_full();
        logic exp_bz;
        logic lo;
        bus.alarm_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.alarm_flag !== 1'b1) begin failures++; $display("[TB] FAIL alarm_flag_on got=%b want=1", bus.alarm_flag); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL alarm_busy_on got=%b want=1", bus.busy); end
        for (int n = 0; n < 30; n++) begin
            lo = (((n / 2) % 2) == 1);
            for (int j = 0; j < 8; j++) begin
                exp_bz = lo ? (((j / 2) % 2) == 1) : ((j % 2) == 1);
                checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL alarm_grant tick=%0d cyc=%0d got=%b want=100", n, j, bus.grant); end
                checks++; if (bus.buzzer !== exp_bz) begin failures++; $display("[TB] FAIL alarm_tone tick=%0d cyc=%0d got=%b want=%b", n, j, bus.buzzer, exp_bz); end
                if (j < 7) @(negedge clk);
            end
            bus.tick_1hz = 1'b1;
            @(negedge clk); bus.tick_1hz = 1'b0;
        end
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL alarm_timeout_grant got=%b want=000", bus.grant); end
        checks++; if (bus.alarm_flag !== 1'b0) begin failures++; $display("[TB] FAIL alarm_timeout_flag got=%b want=0", bus.alarm_flag); end
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL alarm_timeout_buzzer got=%b want=0", bus.buzzer); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL alarm_no_retrigger cyc=%0d got=%b want=000", k, bus.grant); end
        end
        bus.alarm_req = 1'b0;
        @(negedge clk); bus.alarm_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL alarm_rearm got=%b want=100", bus.grant); end
        bus.alarm_stop = 1'b1;
        @(negedge clk); bus.alarm_stop = 1'b0; bus.alarm_req = 1'b0;
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL alarm_stop_grant got=%b want=000", bus.grant); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_preempt();
        int cnt;
        bus.chime_count = 4'd5; bus.chime_req = 1'b1;
        @(negedge clk); bus.chime_req = 1'b0;
        repeat (50) @(negedge clk);
        bus.alarm_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL preempt_grant got=%b want=100", bus.grant); end
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL preempt_tone_restart got=%b want=0", bus.buzzer); end
        bus.key_req = 1'b1;
        @(negedge clk); bus.key_req = 1'b0;
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL key_in_alarm got=%b want=100", bus.grant); end
        for (int t = 0; t < 4; t++) begin
            repeat (3) @(negedge clk);
            bus.tick_1hz = 1'b1;
            @(negedge clk); bus.tick_1hz = 1'b0;
        end
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL preempt_still_alarm got=%b want=100", bus.grant); end
        bus.alarm_stop = 1'b1;
        @(negedge clk); bus.alarm_stop = 1'b0; bus.alarm_req = 1'b0;
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL preempt_stop got=%b want=000", bus.grant); end
        @(negedge clk);
        checks++; if (bus.grant !== 3'b010) begin failures++; $display("[TB] FAIL pending_launch got=%b want=010", bus.grant); end
        cnt = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.grant !== 3'b010) break;
            cnt++;
        end
        checks++; if (cnt !== 1800) begin failures++; $display("[TB] FAIL pending_full_length got=%0d want=1800", cnt); end
        @(negedge clk);
    endtask

    task automatic test_key();
        int cnt;
        logic exp_bz;
        bus.key_req = 1'b1;
        @(negedge clk); bus.key_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            exp_bz = ((i % 2) == 1);
            checks++; if (bus.grant !== 3'b001) begin failures++; $display("[TB] FAIL key_grant cyc=%0d got=%b want=001", i, bus.grant); end
            checks++; if (bus.buzzer !== exp_bz) begin failures++; $display("[TB] FAIL key_tone cyc=%0d got=%b want=%b", i, bus.buzzer, exp_bz); end
            if (i == 20) bus.key_req = 1'b1;
            if (i == 21) bus.key_req = 1'b0;
            @(negedge clk);
        end
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL key_end_grant got=%b want=000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL key_end_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        bus.chime_count = 4'd1; bus.chime_req = 1'b1;
        @(negedge clk); bus.chime_req = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_req = 1'b1;
        @(negedge clk); bus.key_req = 1'b0;
        checks++; if (bus.grant !== 3'b010) begin failures++; $display("[TB] FAIL key_in_chime_grant got=%b want=010", bus.grant); end
        checks++; if (bus.buzzer !== 1'b1) begin failures++; $display("[TB] FAIL key_in_chime_tone got=%b want=1", bus.buzzer); end
        bus.alarm_stop = 1'b1;
        @(negedge clk); bus.alarm_stop = 1'b0;
        checks++; if (bus.grant !== 3'b010) begin failures++; $display("[TB] FAIL stop_in_chime got=%b want=010", bus.grant); end
        cnt = 12;
        for (int k = 0; k < 400; k++) begin
            if (bus.grant === 3'b000) break;
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt !== 200) begin failures++; $display("[TB] FAIL single_chime_length got=%0d want=200", cnt); end
        @(negedge clk);
    endtask

    task automatic test_count_saturate();
        int cnt;
        logic [3:0] vals [2];
        vals[0] = 4'd0;
        vals[1] = 4'd15;
        for (int v = 0; v < 2; v++) begin
            bus.chime_count = vals[v]; bus.chime_req = 1'b1;
            @(negedge clk); bus.chime_req = 1'b0;
            cnt = 0;
            for (int k = 0; k < 6000; k++) begin
                if (bus.grant !== 3'b010) break;
                cnt++;
                @(negedge clk);
            end
            checks++; if (cnt !== 4600) begin failures++; $display("[TB] FAIL chime_count_%0d_length got=%0d want=4600", vals[v], cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bus.alarm_req = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL rstmid_alarm_entry got=%b want=100", bus.grant); end
        bus.chime_count = 4'd4; bus.chime_req = 1'b1;
        @(negedge clk); bus.chime_req = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_alarm_grant got=%b want=000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_alarm_busy got=%b want=0", bus.busy); end
        checks++; if (bus.alarm_flag !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_alarm_flag got=%b want=0", bus.alarm_flag); end
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_alarm_buzzer got=%b want=0", bus.buzzer); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("[TB] FAIL rstmid_armed_after got=%b want=100", bus.grant); end
        bus.alarm_stop = 1'b1;
        @(negedge clk); bus.alarm_stop = 1'b0; bus.alarm_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_pending_lost cyc=%0d got=%b want=000", k, bus.grant); end
            @(negedge clk);
        end
        bus.chime_count = 4'd2; bus.chime_req = 1'b1;
        @(negedge clk); bus.chime_req = 1'b0;
        repeat (250) @(negedge clk);
        checks++; if (bus.grant !== 3'b010) begin failures++; $display("[TB] FAIL rstmid_gap_grant got=%b want=010", bus.grant); end
        checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_gap_silent got=%b want=0", bus.buzzer); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_gap_grant_rst got=%b want=000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_gap_busy_rst got=%b want=0", bus.busy); end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_gap_after got=%b want=0", bus.busy); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        bus.tick_1hz    = 1'b0;
        bus.alarm_req   = 1'b0;
        bus.alarm_stop  = 1'b0;
        bus.chime_req   = 1'b0;
        bus.chime_count = 4'd0;
        bus.key_req     = 1'b0;
        test_reset();
        test_chime_three();
        test_alarm_full();
        test_preempt();
        test_key();
        test_count_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
